toggle_rx_ack: RTL and testbench

TOGGLE_RX_ACK -- requirements
Module: toggle_rx_ack

---
 rtl/toggle_rx_ack_if.sv | 40 ++++
 rtl/toggle_rx_ack.sv | 112 +++++++++++
 tb/tb_toggle_rx_ack.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/toggle_rx_ack_if.sv
// Handshake bundle for toggle_rx_ack.
//   req_tgl   : toggle level from the sender domain (one event per transition)
//   evt_valid : at least one event is pending
//   evt_ready : consumer accepts one event when high together with evt_valid
//   ack_tgl   : toggle returned to the sender, flips once per accepted event
//   pend_cnt  : number of pending events
//   ovf       : sticky overflow flag
//   ovf_clr   : synchronous clear of ovf
// Modports: slave = receiver block, master = sender/consumer environment.
interface toggle_rx_ack_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             req_tgl;
  logic             evt_valid;
  logic             evt_ready;
  logic             ack_tgl;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;
  logic             ovf_clr;

  modport master (
    output req_tgl,
    output evt_ready,
    output ovf_clr,
    input  evt_valid,
    input  ack_tgl,
    input  pend_cnt,
    input  ovf
  );

  modport slave (
    input  req_tgl,
    input  evt_ready,
    input  ovf_clr,
    output evt_valid,
    output ack_tgl,
    output pend_cnt,
    output ovf
  );
endinterface

// File: rtl/toggle_rx_ack.sv
// Toggle-event receiver: synchronises an asynchronous request toggle into clk_b, counts
// pending events, presents them on a valid/ready handshake and returns an acknowledge toggle.
// Ports:
//   clk_b    : clock, all flops on its rising edge
//   rst_b_n  : asynchronous active-low reset
//   bus      : toggle_rx_ack_if.slave (req_tgl, evt_ready, ovf_clr in; evt_valid, ack_tgl,
//              pend_cnt, ovf out)
// Optional feature: define TOGGLE_RX_OVF_DET_EN to build the sticky overflow detector;
// otherwise ovf is tied low and ovf_clr is ignored (pend_cnt still saturates).
module toggle_rx_ack #(
  parameter int unsigned SYNC_SIZE = 3,
  parameter int unsigned CNT_W     = 4
) (
  input logic             clk_b,
  input logic             rst_b_n,
  toggle_rx_ack_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StDeliver} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [SYNC_SIZE-1:0] sync_q, sync_d;
  logic                 hist_q, hist_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  state_e               state_q, state_d;

  logic evt_edge;
  logic accept;
  logic drop;

  assign evt_edge = sync_q[SYNC_SIZE-1] ^ hist_q;
  assign accept   = (state_q == StDeliver) & bus.evt_ready;
  // An edge arriving while saturated and not offset by an accept is lost.
  assign drop     = evt_edge & ~accept & (cnt_q == CntMax);

  always_comb begin
    sync_d  = {sync_q[SYNC_SIZE-2:0], bus.req_tgl};
    hist_d  = sync_q[SYNC_SIZE-1];
    cnt_d   = cnt_q;
    ack_d   = ack_q ^ accept;
    state_d = state_q;

    // Edge and accept together cancel out: count unchanged.
    if (evt_edge && !accept && !drop) begin
      cnt_d = cnt_q + CntOne;
    end else if (accept && !evt_edge) begin
      cnt_d = cnt_q - CntOne;
    end

    unique case (state_q)
      StIdle: begin
        if (evt_edge) state_d = StDeliver;
      end
      StDeliver: begin
        if ((cnt_q == CntOne) && accept && !evt_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      state_q <= StIdle;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      state_q <= state_d;
    end
  end

`ifdef TOGGLE_RX_OVF_DET_EN
  logic ovf_q, ovf_d;

  // A drop wins over a simultaneous clear so no overflow is ever missed.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = bus.ovf_clr ^ drop;
  assign bus.ovf    = 1'b0;
`endif

  assign bus.evt_valid = (state_q == StDeliver);
  assign bus.ack_tgl   = ack_q;
  assign bus.pend_cnt  = cnt_q;

endmodule

// File: tb/tb_toggle_rx_ack.sv
// Directed bench for toggle_rx_ack with SYNC_SIZE=3, CNT_W=2. Inputs change on the falling
// edge, outputs are sampled on the falling edge after each rising edge.
module tb_toggle_rx_ack;

  localparam int unsigned SyncSize = 3;
  localparam int unsigned CntW     = 2;

`ifdef TOGGLE_RX_OVF_DET_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  logic clk_b = 1'b0;
  logic rst_b_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_b = ~clk_b;

  toggle_rx_ack_if #(.CNT_W(CntW)) bus_if ();

  toggle_rx_ack #(
    .SYNC_SIZE (SyncSize),
    .CNT_W     (CntW)
  ) dut (
    .clk_b   (clk_b),
    .rst_b_n (rst_b_n),
    .bus     (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_b);
      @(negedge clk_b);
    end
  endtask

  task automatic do_reset(input logic req_lvl);
    @(negedge clk_b);
    #2;
    rst_b_n = 1'b0;
    bus_if.req_tgl   = req_lvl;
    bus_if.evt_ready = 1'b0;
    bus_if.ovf_clr   = 1'b0;
    tick(2);
    rst_b_n = 1'b1;
  endtask

  task automatic toggle_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.req_tgl = ~bus_if.req_tgl;
      tick(2);
    end
  endtask

  initial begin
    bus_if.req_tgl   = 1'b0;
    bus_if.evt_ready = 1'b0;
    bus_if.ovf_clr   = 1'b0;
    tick(2);

    // Asynchronous reset takes effect between edges.
    #2 rst_b_n = 1'b0;
    #1;
    check_eq("rst_valid", bus_if.evt_valid, 0);
    check_eq("rst_cnt", bus_if.pend_cnt, 0);
    check_eq("rst_ack", bus_if.ack_tgl, 0);
    check_eq("rst_ovf", bus_if.ovf, 0);
    tick(2);

    // Single event latency with consumer always ready.
    rst_b_n = 1'b1;
    bus_if.evt_ready = 1'b1;
    bus_if.req_tgl   = 1'b1;
    tick(3);
    check_eq("lat_valid_e3", bus_if.evt_valid, 0);
    tick(1);
    check_eq("lat_valid_e4", bus_if.evt_valid, 1);
    check_eq("lat_cnt_e4", bus_if.pend_cnt, 1);
    check_eq("lat_ack_e4", bus_if.ack_tgl, 0);
    tick(1);
    check_eq("lat_valid_e5", bus_if.evt_valid, 0);
    check_eq("lat_cnt_e5", bus_if.pend_cnt, 0);
    check_eq("lat_ack_e5", bus_if.ack_tgl, 1);

    // Three queued events, then drained one per cycle.
    do_reset(1'b0);
    toggle_n(3);
    tick(4);
    check_eq("q3_cnt", bus_if.pend_cnt, 3);
    check_eq("q3_valid", bus_if.evt_valid, 1);
    check_eq("q3_ack", bus_if.ack_tgl, 0);
    bus_if.evt_ready = 1'b1;
    tick(1);
    check_eq("d1_ack", bus_if.ack_tgl, 1);
    check_eq("d1_cnt", bus_if.pend_cnt, 2);
    tick(1);
    check_eq("d2_ack", bus_if.ack_tgl, 0);
    check_eq("d2_cnt", bus_if.pend_cnt, 1);
    check_eq("d2_valid", bus_if.evt_valid, 1);
    tick(1);
    check_eq("d3_ack", bus_if.ack_tgl, 1);
    check_eq("d3_cnt", bus_if.pend_cnt, 0);
    check_eq("d3_valid", bus_if.evt_valid, 0);
    tick(1);
    check_eq("idle_ready_ack", bus_if.ack_tgl, 1);
    check_eq("idle_ready_cnt", bus_if.pend_cnt, 0);
    bus_if.evt_ready = 1'b0;

    // Saturation and overflow.
    do_reset(1'b0);
    toggle_n(4);
    tick(4);
    check_eq("sat_cnt", bus_if.pend_cnt, 3);
    check_eq("sat_ovf", bus_if.ovf, 32'(OvfExp));
    bus_if.ovf_clr = 1'b1;
    tick(1);
    bus_if.ovf_clr = 1'b0;
    check_eq("clr_ovf", bus_if.ovf, 0);
    check_eq("clr_cnt", bus_if.pend_cnt, 3);

    // Edge and accept in the same cycle.
    do_reset(1'b0);
    toggle_n(1);
    tick(4);
    check_eq("one_cnt", bus_if.pend_cnt, 1);
    bus_if.req_tgl = ~bus_if.req_tgl;
    tick(3);
    bus_if.evt_ready = 1'b1;
    tick(1);
    bus_if.evt_ready = 1'b0;
    check_eq("both_cnt", bus_if.pend_cnt, 1);
    check_eq("both_ack", bus_if.ack_tgl, 1);
    check_eq("both_valid", bus_if.evt_valid, 1);
    tick(2);
    check_eq("both_hold_ack", bus_if.ack_tgl, 1);

    // Reset mid-operation with pending events and a nonzero ack.
    do_reset(1'b0);
    toggle_n(4);
    tick(4);
    bus_if.evt_ready = 1'b1;
    tick(1);
    bus_if.evt_ready = 1'b0;
    check_eq("pre_cnt", bus_if.pend_cnt, 2);
    check_eq("pre_ack", bus_if.ack_tgl, 1);
    #2 rst_b_n = 1'b0;
    #1;
    check_eq("mid_cnt", bus_if.pend_cnt, 0);
    check_eq("mid_valid", bus_if.evt_valid, 0);
    check_eq("mid_ack", bus_if.ack_tgl, 0);
    check_eq("mid_ovf", bus_if.ovf, 0);

    // Release with req_tgl high yields exactly one event.
    bus_if.req_tgl = 1'b1;
    tick(1);
    rst_b_n = 1'b1;
    tick(6);
    check_eq("base1_cnt", bus_if.pend_cnt, 1);

    // Release with req_tgl low yields none.
    do_reset(1'b0);
    tick(6);
    check_eq("base0_cnt", bus_if.pend_cnt, 0);
    check_eq("base0_valid", bus_if.evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
